// File: rtl/loader_pkg.sv
// Shared types and constants for the serial instruction loader.
package loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory signal bundle for instr_loader.
interface loader_if #(
    parameter int ADDR_W = 12
) (
    input logic CLK
);
    import loader_pkg::*;

    logic              start;
    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    // master drives the byte stream and observes the loader; slave is the loader side
    modport master (
        input  CLK,
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
    );

    modport slave (
        input  CLK,
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
    );

endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory, holding the CPU in reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);
    localparam longint unsigned    MAX_WORDS = 64'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   count_q, count_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

    logic                accept;
    logic [WORD_W-1:0]   len_word;
    logic                len_bad;

    // The high length byte is parked in count_q[15:8] until the low byte arrives.
    assign accept   = byte_valid && byte_ready;
    assign len_word = {count_q[WORD_W-1:BYTE_W], byte_data};
    assign len_bad  = (len_word == '0) || (64'(len_word) > MAX_WORDS);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (accept) begin
            csum_d = csum_q ^ byte_data;
        end
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    addr_d  = BASE;
                    count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_HI: begin
                if (accept) begin
                    count_d = {byte_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    count_d = len_word;
                    state_d = len_bad ? ERR : DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    wdata_d[WORD_W-1:BYTE_W] = byte_data;
                    state_d                  = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    wdata_d[BYTE_W-1:0] = byte_data;
                    state_d             = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q - WORD_W'(1);
                if (count_q != WORD_W'(1)) begin
                    state_d = DATA_HI;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            wdata_q <= '0;
            count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
`ifdef LOADER_CHECKSUM_EN
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK: byte_ready = 1'b1;
`else
            LEN_HI, LEN_LO, DATA_HI, DATA_LO:      byte_ready = 1'b1;
`endif
            default:                               byte_ready = 1'b0;
        endcase
    end

    // RST gates the strobe so an aborted WRITE never reaches memory.
    assign mem_we    = (state_q == WRITE) && !RST;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst   = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);

endmodule
